// File: rtl/tinyvga_frame_monitor.sv
// tinyvga_frame_monitor: receive-side checker for the TinyVGA PMOD stream.
// Unpacks RGB222 + syncs, recovers pixel coordinates from sync edges,
// streams active pixels and reports per-frame timing and a checksum.
module tinyvga_frame_monitor #(
   parameter int H_ACTIVE        = 640,
   parameter int H_SYNC          = 96,
   parameter int H_BP            = 48,
   parameter int H_TOTAL         = 800,
   parameter int V_ACTIVE        = 480,
   parameter int V_SYNC          = 2,
   parameter int V_BP            = 33,
   parameter int V_TOTAL         = 525,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  pmod_in,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [5:0]  pix_rgb,
   output logic        frame_done,
   output logic [15:0] frame_sum,
   output logic [9:0]  frame_lines,
   output logic [10:0] line_len,
   output logic        timing_ok,
   output logic        locked
);

   localparam logic [10:0] H_START   = 11'(H_SYNC + H_BP);
   localparam logic [10:0] H_STOP    = 11'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0]  V_START   = 10'(V_SYNC + V_BP);
   localparam logic [9:0]  V_STOP    = 10'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
   localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
   localparam logic [9:0]  V_SYNC_W  = 10'(V_SYNC);
   localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
   localparam logic        SYNC_INV  = (SYNC_ACTIVE_LOW != 0);

   typedef enum logic {
      UNARMED,
      ARMED
   } state_t;

   state_t      state;

   // input stage (syncs held already normalised to active-high)
   logic        s1_hs;
   logic        s1_vs;
   logic [5:0]  s1_rgb;
   logic        hs_prev;

   // timing recovery
   logic [10:0] hc;
   logic [9:0]  vc;
   logic        vs_line;
   logic        have_line;
   logic [15:0] sum;
   logic        err;

   // combinational decode
   logic        hle;
   logic        hte;
   logic        vle;
   logic        vte;
   logic [10:0] hc_inc;
   logic [10:0] pos;
   logic [9:0]  vc_inc;
   logic [9:0]  vpos;
   logic        line_err;
   logic        hs_err;
   logic        vs_err;
   logic        err_now;
   logic        active;
   logic        ok_new;

   // Register the PMOD byte once; syncs normalised so reset value 0 means idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_hs   <= 1'b0;
         s1_vs   <= 1'b0;
         s1_rgb  <= '0;
         hs_prev <= 1'b0;
      end else begin
         s1_hs   <= pmod_in[7] ^ SYNC_INV;
         s1_vs   <= pmod_in[3] ^ SYNC_INV;
         s1_rgb  <= {pmod_in[0], pmod_in[4], pmod_in[1], pmod_in[5], pmod_in[2], pmod_in[6]};
         hs_prev <= s1_hs;
      end
   end

   // Edge detection, position of the byte now in S1, and timing checks.
   // hc holds the position of the previous S1 byte, so pos is the current one.
   always_comb begin
      hle      = s1_hs & ~hs_prev;
      hte      = ~s1_hs & hs_prev;
      hc_inc   = (hc == '1) ? hc : hc + 11'd1;
      pos      = hle ? '0 : hc_inc;
      vle      = hle & s1_vs & ~vs_line;
      vte      = hle & ~s1_vs & vs_line;
      vc_inc   = (vc == '1) ? vc : vc + 10'd1;
      vpos     = vc;
      if (vle) begin
         vpos = '0;
      end else if (hle) begin
         vpos = vc_inc;
      end
      line_err = hle & have_line & (hc_inc != H_TOTAL_W);
      hs_err   = hte & have_line & (hc_inc != H_SYNC_W);
      vs_err   = vte & (vc_inc != V_SYNC_W);
      err_now  = err | line_err | hs_err | vs_err;
      active   = (state == ARMED) & have_line
               & (pos >= H_START) & (pos < H_STOP)
               & (vpos >= V_START) & (vpos < V_STOP);
      ok_new   = ~err_now & (({1'b0, vc} + 11'd1) == V_TOTAL_W);
   end

   // Horizontal/vertical counters and the measured line length
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc        <= '0;
         vc        <= '0;
         vs_line   <= 1'b0;
         have_line <= 1'b0;
         line_len  <= '0;
      end else begin
         hc <= pos;
         vc <= vpos;
         if (hle) begin
            vs_line   <= s1_vs;
            have_line <= 1'b1;
            if (have_line) begin
               line_len <= hc_inc;
            end
         end
      end
   end

   // Registered pixel stream, two clocks behind the PMOD byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_valid <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_rgb   <= '0;
      end else begin
         pix_valid <= active;
         if (active) begin
            pix_x   <= 10'(pos - H_START);
            pix_y   <= vpos - V_START;
            pix_rgb <= s1_rgb;
         end else begin
            pix_x   <= '0;
            pix_y   <= '0;
            pix_rgb <= '0;
         end
      end
   end

   // Frame checksum and sticky error flag, both restarted at every VLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= '0;
         err <= 1'b0;
      end else begin
         if (vle) begin
            sum <= '0;
            err <= 1'b0;
         end else begin
            err <= err_now;
            if (pix_valid) begin
               sum <= {sum[14:0], sum[15]} ^ {10'b0, pix_rgb};
            end
         end
      end
   end

   // Arming FSM and frame report; the first VLE only arms (partial frame dropped).
   // The report folds in checks raised on the VLE cycle itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= UNARMED;
         frame_done  <= 1'b0;
         frame_sum   <= '0;
         frame_lines <= '0;
         timing_ok   <= 1'b0;
         locked      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            UNARMED: begin
               if (vle) begin
                  state <= ARMED;
               end
            end
            ARMED: begin
               if (vle) begin
                  frame_done  <= 1'b1;
                  frame_sum   <= sum;
                  frame_lines <= vc + 10'd1;
                  timing_ok   <= ok_new;
                  locked      <= ok_new & timing_ok;
               end
            end
            default: state <= UNARMED;
         endcase
      end
   end

endmodule

// File: tb/tb_tinyvga_frame_monitor.sv
// tb_tinyvga_frame_monitor: drives a scaled-down VGA stream into an
// active-low and an active-high sync instance and checks both against a
// frame-level reference model.
module tb_tinyvga_frame_monitor;

   localparam int HA = 16;
   localparam int HS = 4;
   localparam int HB = 3;
   localparam int HT = 28;
   localparam int VA = 10;
   localparam int VS = 2;
   localparam int VB = 3;
   localparam int VT = 18;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] pmod = 8'h88;
   logic [7:0] pmod_hi;

   logic        pv   [2];
   logic [9:0]  px   [2];
   logic [9:0]  py   [2];
   logic [5:0]  prgb [2];
   logic        fd   [2];
   logic [15:0] fs   [2];
   logic [9:0]  fl   [2];
   logic [10:0] ll   [2];
   logic        tok  [2];
   logic        lk   [2];

   assign pmod_hi = pmod ^ 8'h88;

   always #5 clk = ~clk;

   tinyvga_frame_monitor #(
      .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
      .SYNC_ACTIVE_LOW(1)
   ) dut_lo (
      .clk(clk), .rst_n(rst_n), .pmod_in(pmod),
      .pix_valid(pv[0]), .pix_x(px[0]), .pix_y(py[0]), .pix_rgb(prgb[0]),
      .frame_done(fd[0]), .frame_sum(fs[0]), .frame_lines(fl[0]),
      .line_len(ll[0]), .timing_ok(tok[0]), .locked(lk[0])
   );

   tinyvga_frame_monitor #(
      .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
      .SYNC_ACTIVE_LOW(0)
   ) dut_hi (
      .clk(clk), .rst_n(rst_n), .pmod_in(pmod_hi),
      .pix_valid(pv[1]), .pix_x(px[1]), .pix_y(py[1]), .pix_rgb(prgb[1]),
      .frame_done(fd[1]), .frame_sum(fs[1]), .frame_lines(fl[1]),
      .line_len(ll[1]), .timing_ok(tok[1]), .locked(lk[1])
   );

   typedef struct {
      bit        pv;
      bit [9:0]  x;
      bit [9:0]  y;
      bit [5:0]  rgb;
      bit        fd;
      bit [15:0] sum;
      bit [9:0]  lines;
      bit [10:0] len;
      bit        ok;
      bit        lk;
   } exp_t;

   exp_t      q[$];
   exp_t      me;
   int        n_tests = 0;
   int        n_fail  = 0;

   // reference model state (frame level)
   bit        armed_m  = 1'b0;
   bit        prev_ok  = 1'b0;
   bit        cur_err  = 1'b0;
   bit [15:0] cur_sum  = '0;
   int        cur_lines = 0;
   int        last_len  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Outputs for the byte driven two clocks earlier are compared each negedge
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && q.size() >= 3) begin
            me = q.pop_front();
            for (int d = 0; d < 2; d++) begin
               check($sformatf("d%0d_pix_valid", d), 64'(pv[d]), 64'(me.pv));
               if (me.pv)
                  check($sformatf("d%0d_pix_xy_rgb", d), 64'({px[d], py[d], prgb[d]}),
                        64'({me.x, me.y, me.rgb}));
               check($sformatf("d%0d_frame_done", d), 64'(fd[d]), 64'(me.fd));
               if (me.fd) begin
                  check($sformatf("d%0d_frame_sum", d), 64'(fs[d]), 64'(me.sum));
                  check($sformatf("d%0d_frame_lines", d), 64'(fl[d]), 64'(me.lines));
                  check($sformatf("d%0d_line_len", d), 64'(ll[d]), 64'(me.len));
                  check($sformatf("d%0d_timing_ok", d), 64'(tok[d]), 64'(me.ok));
                  check($sformatf("d%0d_locked", d), 64'(lk[d]), 64'(me.lk));
               end
            end
         end
      end
   end

   task automatic drive(input logic [7:0] b, input exp_t e);
      @(posedge clk);
      #1;
      pmod = b;
      q.push_back(e);
   endtask

   task automatic drive_idle(input int n);
      exp_t e;
      e = '{default: '0};
      for (int i = 0; i < n; i++) drive(8'h88, e);
   endtask

   // One line of the stream; model decides reports, pixels and checksum
   task automatic drive_line(input int l, input int len, input int hsw, input int mode, input bit mark);
      exp_t       e;
      logic [5:0] rgb;
      logic [7:0] b;
      bit         hs, vs, win, ok;
      int         x, y;
      for (int p = 0; p < len; p++) begin
         e = '{default: '0};
         if (p == 0) begin
            if (l == 0) begin
               if (armed_m) begin
                  ok       = !cur_err && (cur_lines == VT);
                  e.fd     = 1'b1;
                  e.sum    = cur_sum;
                  e.lines  = 10'(cur_lines);
                  e.len    = 11'(last_len);
                  e.ok     = ok;
                  e.lk     = ok && prev_ok;
                  prev_ok  = ok;
               end
               armed_m   = 1'b1;
               cur_sum   = '0;
               cur_err   = 1'b0;
               cur_lines = 0;
            end
            cur_lines++;
            last_len = len;
            if (len != HT || hsw != HS) cur_err = 1'b1;
         end
         hs  = (p < hsw);
         vs  = (l < VS);
         x   = p - (HS + HB);
         y   = l - (VS + VB);
         win = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
         rgb = '0;
         if (win) begin
            rgb = (mode == 0) ? 6'((x + y) & 63) : 6'($urandom_range(0, 63));
            if (mark && x == 0 && y == 0) rgb = 6'h2A;
            if (armed_m) begin
               e.pv    = 1'b1;
               e.x     = 10'(x);
               e.y     = 10'(y);
               e.rgb   = rgb;
               cur_sum = {cur_sum[14:0], cur_sum[15]} ^ {10'b0, rgb};
            end
         end
         b = {~hs, rgb[0], rgb[2], rgb[4], ~vs, rgb[1], rgb[3], rgb[5]};
         drive(b, e);
      end
   endtask

   task automatic drive_frame(input int l0, input int l1, input int stretch, input int shortl,
                              input int mode, input bit mark);
      for (int l = l0; l <= l1; l++)
         drive_line(l, (l == stretch) ? HT + 1 : HT, (l == shortl) ? HS - 1 : HS, mode, mark);
   endtask

   task automatic check_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s_d%0d_pix", tag, d), 64'({pv[d], px[d], py[d], prgb[d]}), 64'(0));
         check($sformatf("%s_d%0d_report", tag, d),
               64'({fd[d], fs[d], fl[d], ll[d], tok[d], lk[d]}), 64'(0));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      pmod  = 8'h88;
      repeat (2) @(posedge clk);
      #2;
      check_zero("reset");
      rst_n = 1'b1;

      // partial frame, then first VLE only arms
      drive_frame(10, VT - 1, -1, -1, 0, 1'b0);
      drive_frame(0, VT - 1, -1, -1, 0, 1'b1);                          // pattern + 2A marker
      drive_frame(0, VT - 1, -1, -1, 0, 1'b0);                          // ok, locks
      drive_frame(0, VT - 1, $urandom_range(0, VT - 1), -1, 1, 1'b0);   // stretched line
      drive_frame(0, VT - 1, -1, -1, 1, 1'b0);                          // ok, not locked
      drive_frame(0, VT - 1, -1, -1, 1, 1'b0);                          // locked again
      drive_frame(0, VT - 1, -1, $urandom_range(0, VT - 1), 1, 1'b0);   // short hsync
      drive_frame(0, VT - 1, -1, -1, 1, 1'b0);
      drive_frame(0, 7, -1, -1, 1, 1'b0);

      // asynchronous reset mid-frame, observed before any clock edge
      #1;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      q.delete();
      pmod      = 8'h88;
      armed_m   = 1'b0;
      prev_ok   = 1'b0;
      cur_err   = 1'b0;
      cur_sum   = '0;
      cur_lines = 0;
      last_len  = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // no hsync long enough for hc to saturate: no pixels, no reports
      drive_idle(2200);
      drive_frame(3, VT - 1, -1, -1, 0, 1'b0);
      drive_frame(0, VT - 1, -1, -1, 1, 1'b0);
      drive_frame(0, 3, -1, -1, 1, 1'b0);
      drive_idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
